// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC excitation generator.
package lpc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned CNT_W  = 10;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // One Galois step: shift right, fold the mask in when a 1 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ LFSR_MASK;
    return n;
  endfunction

endpackage

// File: rtl/lpc_lfsr16.sv
// 16-bit Galois LFSR noise source, advanced one step per enable.
module lpc_lfsr16
  import lpc_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] lfsr
);

  // State register; reloads the seed on reset, steps only when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= SEED;
    else if (en) lfsr <= lfsr_step(lfsr);
  end

endmodule

// File: rtl/lpc_excitation_gen.sv
// Excitation source for the LPC synthesis filter: impulse train for voiced
// frames, scaled LFSR noise for unvoiced frames, one sample per sample_tick.
module lpc_excitation_gen
  import lpc_pkg::*;
#(
  parameter int unsigned FRAME_LEN   = 180,
  parameter int unsigned NOISE_SHIFT = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              prm_valid,
  output logic              prm_ready,
  input  logic [7:0]        prm_pitch,
  input  logic [DATA_W-1:0] prm_gain,
  output logic [DATA_W-1:0] x,
  output logic              v,
  output logic              frame_start,
  output logic              underrun
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t state_q, state_d;

  logic                     pending;
  logic [7:0]               sh_pitch;
  logic [DATA_W-1:0]        sh_gain;
  logic [7:0]               act_pitch;
  logic [DATA_W-1:0]        act_gain;
  logic [7:0]               phase;
  logic [CNT_W-1:0]         cnt;
  logic [15:0]              lfsr;

  logic                     accept;
  logic                     emit;
  logic                     load;
  logic                     last;
  logic                     carry;
  logic [7:0]               eff_pitch;
  logic signed [DATA_W-1:0] eff_gain;
  logic [7:0]               ph_eff;
  logic [7:0]               phase_d;
  logic signed [DATA_W-1:0] noise;
  logic signed [PROD_W-1:0] prod;
  logic [DATA_W-1:0]        sample;
  logic                     unused_prod;

  assign prm_ready   = ~pending;
  assign accept      = prm_valid & ~pending;
  assign unused_prod = ^{prod[PROD_W-1], prod[14:0]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state plus per-tick emit/load/end-of-frame decode.
  // A RUN tick with cnt==0 is always a frame boundary, and pending is
  // guaranteed set there because RUN is only kept past the last sample
  // when a set was waiting.
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    load    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick && pending) begin
          emit    = 1'b1;
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (sample_tick) begin
          emit = 1'b1;
          load = (cnt == '0);
          last = (cnt == LAST_IDX);
          if (last && !pending) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sample datapath: effective parameters, pitch phase and noise scaling.
  always_comb begin
    eff_pitch = load ? sh_pitch : act_pitch;
    eff_gain  = load ? sh_gain  : act_gain;
    carry     = (state_q == RUN) && (act_pitch != '0);
    ph_eff    = phase;
    if (load && (!carry || phase >= sh_pitch)) ph_eff = '0;
    phase_d = '0;
    if (eff_pitch != '0 && ph_eff != eff_pitch - 8'd1) phase_d = ph_eff + 8'd1;
    noise  = $signed(lfsr) >>> NOISE_SHIFT;
    prod   = PROD_W'(noise) * PROD_W'(eff_gain);
    sample = '0;
    if (eff_pitch == '0)   sample = prod[30:15];
    else if (ph_eff == '0) sample = eff_gain;
  end

  // Parameter shadow register; negative gains are clamped on the way in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= 1'b0;
      sh_pitch <= '0;
      sh_gain  <= '0;
    end else if (accept) begin
      pending  <= 1'b1;
      sh_pitch <= prm_pitch;
      sh_gain  <= prm_gain[DATA_W-1] ? '0 : prm_gain;
    end else if (load) begin
      pending  <= 1'b0;
    end
  end

  // Active parameter set, sample counter and pitch phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_pitch <= '0;
      act_gain  <= '0;
      cnt       <= '0;
      phase     <= '0;
    end else if (emit) begin
      if (load) begin
        act_pitch <= sh_pitch;
        act_gain  <= sh_gain;
      end
      cnt   <= last ? '0 : cnt + CNT_W'(1);
      phase <= phase_d;
    end
  end

  // Registered outputs and the sticky underrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x           <= '0;
      v           <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      v           <= emit;
      frame_start <= load;
      if (emit) x <= sample;
      if (last && !pending) underrun <= 1'b1;
    end
  end

  lpc_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (emit),
    .lfsr (lfsr)
  );

endmodule
